// File: rtl/dmem_responder_pkg.sv
// Shared store-size codes, default geometry/latency and store lane decode
// for the data-memory responder.
package dmem_responder_pkg;

    localparam logic [1:0] MEM_SZ_BYTE = 2'b00;
    localparam logic [1:0] MEM_SZ_HALF = 2'b01;
    localparam logic [1:0] MEM_SZ_WORD = 2'b10;

    localparam int DMEM_DEPTH  = 1024;
    localparam int DMEM_RD_LAT = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } rd_state_e;

    // A store commits only when naturally aligned for its size.
    function automatic logic store_ok(input logic [1:0] sz, input logic [1:0] off);
        case (sz)
            MEM_SZ_BYTE: store_ok = 1'b1;
            MEM_SZ_HALF: store_ok = (off[0] == 1'b0);
            MEM_SZ_WORD: store_ok = (off == 2'b00);
            default:     store_ok = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [1:0] sz, input logic [1:0] off);
        case (sz)
            MEM_SZ_BYTE: store_be = 4'b0001 << off;
            MEM_SZ_HALF: store_be = off[1] ? 4'b1100 : 4'b0011;
            MEM_SZ_WORD: store_be = 4'b1111;
            default:     store_be = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised RAM built from four byte lanes: one byte-enabled write port
// and one registered read port (read-before-write on a same-edge collision).
module dmem_array #(
    parameter  int DEPTH = 1024,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                we_i,
    input  logic [3:0]          be_i,
    input  logic [AW-1:0]       wr_idx_i,
    input  logic [3:0][7:0]     wdata_i,
    input  logic                rd_en_i,
    input  logic [AW-1:0]       rd_idx_i,
    output logic [3:0][7:0]     rdata_o
);

    for (genvar l = 0; l < 4; l++) begin : g_lane
        logic [7:0] mem [DEPTH];
        logic [7:0] rd_q;

        // Storage is deliberately not reset; only the read register is.
        always_ff @(posedge clk_i) begin
            if (we_i && be_i[l]) mem[wr_idx_i] <= wdata_i[l];
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i)        rd_q <= '0;
            else if (rd_en_i) rd_q <= mem[rd_idx_i];
        end

        assign rdata_o[l] = rd_q;
    end

endmodule

// File: rtl/dmem_responder.sv
// Target end of the MEMORY stage dmem port: latency-programmable loads with a
// ready level, and byte/half/word stores with misalignment rejection.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = DMEM_DEPTH,
    parameter int RD_LATENCY  = DMEM_RD_LAT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wr_data,
    input  logic        mem_wr_enable,
    input  logic [1:0]  mem_wr_size,
    input  logic        mem_rd_enable,
    output logic [31:0] mem_rd_data,
    output logic        mem_rd_ready,
    output logic        mem_wr_misalign
);

    localparam int         AW     = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAT_M1 = 4'(RD_LATENCY - 1);

    rd_state_e       state_q;
    logic [3:0]      cnt_q;
    logic [31:0]     addr_q;
    logic            rdy_q;
    logic            mis_q;

    logic            capture;
    logic            st_ok;
    logic [3:0]      st_be;
    logic [3:0][7:0] st_lanes;
    logic [3:0][7:0] ram_q;

    // The RAM word is sampled on the edge that leaves WAIT with the count spent.
    assign capture = (state_q == ST_WAIT) && mem_rd_enable && (cnt_q == 4'd0);

    assign st_ok = store_ok(mem_wr_size, mem_addr[1:0]);
    assign st_be = store_be(mem_wr_size, mem_addr[1:0]);

    always_comb begin
        st_lanes = mem_wr_data;
        case (mem_wr_size)
            MEM_SZ_BYTE: st_lanes = {4{mem_wr_data[7:0]}};
            MEM_SZ_HALF: st_lanes = {2{mem_wr_data[15:0]}};
            default:     st_lanes = mem_wr_data;
        endcase
    end

    dmem_array #(
        .DEPTH (DEPTH_WORDS)
    ) u_array (
        .clk_i    (clk),
        .rst_i    (reset),
        .we_i     (mem_wr_enable && st_ok),
        .be_i     (st_be),
        .wr_idx_i (mem_addr[AW+1:2]),
        .wdata_i  (st_lanes),
        .rd_en_i  (capture),
        .rd_idx_i (addr_q[AW+1:2]),
        .rdata_o  (ram_q)
    );

    assign mem_rd_data     = ram_q >> {addr_q[1:0], 3'b000};
    assign mem_rd_ready    = rdy_q;
    assign mem_wr_misalign = mis_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            rdy_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (mem_rd_enable) begin
                        addr_q  <= mem_addr;
                        cnt_q   <= LAT_M1;
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!mem_rd_enable) begin
                        state_q <= ST_IDLE;
                    end else if (cnt_q == 4'd0) begin
                        rdy_q   <= 1'b1;
                        state_q <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (!mem_rd_enable) begin
                        rdy_q   <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (mem_addr != addr_q) begin
                        // Back-to-back load: drop ready and restart the latency.
                        rdy_q   <= 1'b0;
                        addr_q  <= mem_addr;
                        cnt_q   <= LAT_M1;
                        state_q <= ST_WAIT;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) mis_q <= 1'b0;
        else       mis_q <= mem_wr_enable && !st_ok;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Three responders (latency 1, 2, 5) share one stimulus stream; a byte-array
// memory model feeds per-instance scoreboards checked by a negedge monitor.
module tb_dmem_responder;

    localparam int          DEPTH = 1024;
    localparam int          NI    = 3;
    localparam int          LATS [NI] = '{1, 2, 5};
    localparam logic [31:0] AMASK = 32'(4 * DEPTH - 1);

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wr_data = '0;
    logic        mem_wr_enable = 1'b0;
    logic [1:0]  mem_wr_size = '0;
    logic        mem_rd_enable = 1'b0;

    logic [NI-1:0][31:0] rdata;
    logic [NI-1:0]       rdy;
    logic [NI-1:0]       mis;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        dmem_responder #(
            .DEPTH_WORDS (DEPTH),
            .RD_LATENCY  (LATS[g])
        ) u_dut (
            .clk             (clk),
            .reset           (reset),
            .mem_addr        (mem_addr),
            .mem_wr_data     (mem_wr_data),
            .mem_wr_enable   (mem_wr_enable),
            .mem_wr_size     (mem_wr_size),
            .mem_rd_enable   (mem_rd_enable),
            .mem_rd_data     (rdata[g]),
            .mem_rd_ready    (rdy[g]),
            .mem_wr_misalign (mis[g])
        );
    end

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        sbq [NI][$];
    logic [7:0]  mdl [4*DEPTH];
    int          mst [NI];
    logic [31:0] maddr [NI];
    int          mdue [NI];
    logic        mis_exp = 1'b0;

    function automatic logic [31:0] mdl_read(input logic [31:0] a);
        logic [31:0] base;
        logic [31:0] w;
        base = a & AMASK & ~32'h3;
        for (int b = 0; b < 4; b++) w[8*b +: 8] = mdl[int'(base) + b];
        return w >> (8 * a[1:0]);
    endfunction

    function automatic bit wr_legal(input logic [1:0] sz, input logic [31:0] a);
        case (sz)
            2'd0:    return 1'b1;
            2'd1:    return a[0] == 1'b0;
            2'd2:    return a[1:0] == 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: reads see memory as it was before the due edge's store.
    initial forever begin
        @(posedge clk);
        cyc++;
        if (reset) begin
            for (int k = 0; k < NI; k++) mst[k] = 0;
            mis_exp = 1'b0;
        end else begin
            for (int k = 0; k < NI; k++) begin
                case (mst[k])
                    0: if (mem_rd_enable) begin
                        maddr[k] = mem_addr; mdue[k] = cyc + LATS[k]; mst[k] = 1;
                    end
                    1: if (!mem_rd_enable) mst[k] = 0;
                       else if (cyc == mdue[k]) begin
                           sbq[k].push_back('{data: mdl_read(maddr[k]), due: cyc});
                           mst[k] = 2;
                       end
                    default: if (!mem_rd_enable) mst[k] = 0;
                       else if (mem_addr != maddr[k]) begin
                           maddr[k] = mem_addr; mdue[k] = cyc + LATS[k]; mst[k] = 1;
                       end
                endcase
            end
            mis_exp = 1'b0;
            if (mem_wr_enable) begin
                if (wr_legal(mem_wr_size, mem_addr)) begin
                    for (int b = 0; b < (1 << mem_wr_size); b++)
                        mdl[int'((mem_addr + 32'(b)) & AMASK)] = mem_wr_data[8*b +: 8];
                end else begin
                    mis_exp = 1'b1;
                end
            end
        end
    end

    // Monitor: pops on each ready rise, checks hold while ready stays high.
    initial begin
        logic [NI-1:0]       rdy_prev;
        logic [NI-1:0][31:0] dprev;
        exp_t                e;
        rdy_prev = '0;
        dprev = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                rdy_prev = '0;
            end else begin
                for (int k = 0; k < NI; k++) begin
                    if (rdy[k] && !rdy_prev[k]) begin
                        if (sbq[k].size() == 0) begin
                            checks++; failures++;
                            $display("FAIL rd_unexpected L%0d: got ready with %h, required no response", LATS[k], rdata[k]);
                        end else begin
                            e = sbq[k].pop_front();
                            chk($sformatf("rd_data L%0d", LATS[k]), rdata[k], e.data);
                            chk($sformatf("rd_ready_edge L%0d", LATS[k]), 32'(cyc), 32'(e.due));
                        end
                    end else if (rdy[k] && rdy_prev[k]) begin
                        chk($sformatf("rd_hold L%0d", LATS[k]), rdata[k], dprev[k]);
                    end
                    chk($sformatf("misalign L%0d", LATS[k]), 32'(mis[k]), 32'(mis_exp));
                    rdy_prev[k] = rdy[k];
                    dprev[k] = rdata[k];
                end
            end
        end
    end

    task automatic wr(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
        mem_addr = a; mem_wr_size = sz; mem_wr_data = d; mem_wr_enable = 1'b1;
        @(negedge clk);
        mem_wr_enable = 1'b0;
    endtask

    task automatic wait_rdy(input string nm, input bit chk_en, input logic [31:0] exp, input bit wjit);
        int n = 0;
        while (rdy != '1 && n < 40) begin
            mem_wr_enable = wjit && ($urandom_range(0, 2) == 0);
            mem_wr_size = 2'($urandom_range(0, 3));
            mem_wr_data = $urandom;
            @(negedge clk);
            n++;
        end
        mem_wr_enable = 1'b0;
        if (n >= 40) begin
            checks++; failures++;
            $display("FAIL %s timeout: ready=%b required all high", nm, rdy);
        end else if (chk_en) begin
            for (int k = 0; k < NI; k++) chk($sformatf("%s L%0d", nm, LATS[k]), rdata[k], exp);
        end
    endtask

    task automatic rd(input logic [31:0] a, input bit chk_en, input logic [31:0] exp,
                      input int hold, input bit wjit);
        mem_addr = a; mem_rd_enable = 1'b1;
        wait_rdy($sformatf("rd_%h", a), chk_en, exp, wjit);
        repeat (hold) @(negedge clk);
        mem_rd_enable = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            chk("reset_ready", 32'(rdy[k]), 32'd0);
            chk("reset_data", rdata[k], 32'd0);
            chk("reset_misalign", 32'(mis[k]), 32'd0);
        end
        reset = 1'b0;
        @(negedge clk);

        for (int w = 0; w < 64; w++) wr(32'(w * 4), 2'd2, $urandom);

        wr(32'h10, 2'd2, 32'hDEADBEEF);
        rd(32'h10, 1'b1, 32'hDEADBEEF, 3, 1'b0);

        wr(32'h20, 2'd2, 32'h11223344);
        wr(32'h21, 2'd0, 32'h000000AA);
        rd(32'h20, 1'b1, 32'h1122AA44, 0, 1'b0);
        rd(32'h22, 1'b1, 32'h00001122, 1, 1'b0);

        wr(32'h30, 2'd2, 32'h55667788);
        wr(32'h33, 2'd1, 32'h0000BEEF);
        wr(32'h22, 2'd2, 32'hFFFFFFFF);
        wr(32'h24, 2'd3, 32'h12345678);
        rd(32'h30, 1'b1, 32'h55667788, 0, 1'b0);
        rd(32'h20, 1'b1, 32'h1122AA44, 0, 1'b0);

        // Back-to-back load: address moves while every instance is in RESP.
        wr(32'h40, 2'd2, 32'hA0A0A0A0);
        wr(32'h44, 2'd2, 32'hB4B4B4B4);
        mem_addr = 32'h40; mem_rd_enable = 1'b1;
        wait_rdy("relatch_first", 1'b1, 32'hA0A0A0A0, 1'b0);
        mem_addr = 32'h44;
        @(negedge clk);
        chk("relatch_drop", 32'(rdy), 32'd0);
        wait_rdy("relatch_second", 1'b1, 32'hB4B4B4B4, 1'b0);
        mem_rd_enable = 1'b0;
        @(negedge clk);

        // Store lands on the latency-2 sampling edge.
        wr(32'h50, 2'd2, 32'h0BADF00D);
        mem_addr = 32'h50; mem_rd_enable = 1'b1;
        repeat (2) @(negedge clk);
        mem_wr_size = 2'd2; mem_wr_data = 32'h600DCAFE; mem_wr_enable = 1'b1;
        @(negedge clk);
        mem_wr_enable = 1'b0;
        wait_rdy("collision", 1'b0, 32'd0, 1'b0);
        chk("collision_old L2", rdata[1], 32'h0BADF00D);
        chk("collision_new L5", rdata[2], 32'h600DCAFE);
        mem_rd_enable = 1'b0;
        @(negedge clk);
        rd(32'h50, 1'b1, 32'h600DCAFE, 0, 1'b0);

        // Reset while latency-2/5 wait and latency-1 already responds.
        mem_addr = 32'h10; mem_rd_enable = 1'b1;
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1 chk("reset_abort_ready", 32'(rdy), 32'd0);
        mem_rd_enable = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        rd(32'h10, 1'b1, 32'hDEADBEEF, 0, 1'b0);

        wr(32'h1000, 2'd2, 32'hCAFEF00D);
        rd(32'h0, 1'b1, 32'hCAFEF00D, 0, 1'b0);
        rd(32'h1010, 1'b1, 32'hDEADBEEF, 0, 1'b0);

        for (int i = 0; i < 120; i++) begin
            logic [31:0] a;
            int          op;
            a  = 32'($urandom_range(0, 255)) | ($urandom & 32'hFFFF_F000);
            op = $urandom_range(0, 3);
            if (op == 0) begin
                wr(a, 2'($urandom_range(0, 3)), $urandom);
            end else if (op == 3) begin
                mem_addr = a; mem_rd_enable = 1'b1;
                repeat ($urandom_range(1, 4)) @(negedge clk);
                mem_rd_enable = 1'b0;
                @(negedge clk);
            end else begin
                rd(a, 1'b0, 32'd0, $urandom_range(0, 3), 1'b1);
            end
        end

        repeat (10) @(negedge clk);
        for (int k = 0; k < NI; k++)
            chk($sformatf("scoreboard_drain L%0d", LATS[k]), 32'(sbq[k].size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
